// File: rtl/operand_order_seq.sv
// Sequential unsigned magnitude comparator: compares two operands MSB-first, D bits per cycle,
// stops at the first differing chunk and returns gt/eq/swap flags plus max/min ordering.
module operand_order_seq #(
  parameter int W = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] Data_X_i,
  input  logic [W-1:0] Data_Y_i,
  input  logic         ack_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic         gtXY_o,
  output logic         eqXY_o,
  output logic         swap_o,
  output logic [W-1:0] Data_Max_o,
  output logic [W-1:0] Data_Min_o
);

  localparam int NCH = W / D;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [W-1:0]   max_q, max_d, min_q, min_d;
  logic           gt_q, gt_d, eq_q, eq_d, swap_q, swap_d;
  logic           busy_q, busy_d, ready_q, ready_d;
  logic [D-1:0]   x_chunk, y_chunk;
  logic           chunk_gt;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    max_d    = max_q;
    min_d    = min_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    swap_d   = swap_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    x_chunk  = x_q[int'(idx_q) * D +: D];
    y_chunk  = y_q[int'(idx_q) * D +: D];
    chunk_gt = (x_chunk > y_chunk);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = Data_X_i;
          y_d     = Data_Y_i;
          idx_d   = IW'(NCH - 1);
          state_d = CMP;
          busy_d  = 1'b1;
        end
      end
      CMP: begin
        // The first differing chunk from the MSB settles the ordering of the whole word.
        if (x_chunk != y_chunk) begin
          gt_d    = chunk_gt;
          eq_d    = 1'b0;
          swap_d  = ~chunk_gt;
          max_d   = chunk_gt ? x_q : y_q;
          min_d   = chunk_gt ? y_q : x_q;
          state_d = DONE;
          ready_d = 1'b1;
        end else if (idx_q == '0) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          swap_d  = 1'b0;
          max_d   = x_q;
          min_d   = y_q;
          state_d = DONE;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (ack_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      max_q   <= '0;
      min_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      max_q   <= max_d;
      min_q   <= min_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      swap_q  <= swap_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign busy_o     = busy_q;
  assign ready_o    = ready_q;
  assign gtXY_o     = gt_q;
  assign eqXY_o     = eq_q;
  assign swap_o     = swap_q;
  assign Data_Max_o = max_q;
  assign Data_Min_o = min_q;

endmodule
